// File: rtl/rob_mem_responder_pkg.sv
// Shared types and constants for the ROB commit-time memory responder.
package rob_mem_responder_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam logic [31:0] DEF_IO_ADDR    = 32'h0003_0000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_STORE   = 2'd1,
        MEM_IO_ADDR = 2'd2,
        MEM_IO_DATA = 2'd3
    } mem_state_t;

    // Only byte, halfword and word stores reach the bus.
    function automatic logic store_size_ok(input logic [5:0] size);
        return (size == 6'd1) || (size == 6'd2) || (size == 6'd4);
    endfunction

    // Addresses with bits [17:16] == 2'b11 map onto the UART/IO space.
    function automatic logic in_io_space(input logic [1:0] hi_bits);
        return hi_bits == 2'b11;
    endfunction

endpackage

// File: rtl/rob_mem_responder.sv
// Serialises ROB commit-time stores and IO reads onto the byte-wide RAM/IO bus
// and returns a one-cycle completion pulse for each finished request.
module rob_mem_responder
    import rob_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [31:0] IO_ADDR    = DEF_IO_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,
    input  logic                  if_out_mem,
    input  logic [5:0]            out_mem_size,
    input  logic [ADDR_WIDTH-1:0] out_mem_addr,
    input  logic [DATA_WIDTH-1:0] out_mem_data,
    output logic                  if_stored,
    input  logic                  if_out_mem_io,
    output logic                  if_get_mem,
    output logic [DATA_WIDTH-1:0] data_mem,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    mem_state_t            state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [5:0]            size_q;
    logic                  latch_store;
    logic                  stored_d;
    logic                  get_d;
    logic [DATA_WIDTH-1:0] data_mem_d;
    logic                  io_stall;
    logic [8:0]            lane_shift;

    assign io_stall   = in_io_space(addr_q[17:16]) && io_buffer_full;
    assign lane_shift = {cnt_q, 3'b000};
    assign bus_req    = (state_q != MEM_IDLE);

    // Next-state, completion pulses and combinational bus drive.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        latch_store = FALSE;
        stored_d    = FALSE;
        get_d       = FALSE;
        data_mem_d  = data_mem;
        mem_a       = '0;
        mem_dout    = '0;
        mem_wr      = FALSE;

        if (clear) begin
            state_d = MEM_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MEM_IDLE: begin
                    if (if_out_mem) begin
                        latch_store = TRUE;
                        cnt_d       = '0;
                        if (store_size_ok(out_mem_size)) begin
                            state_d = MEM_STORE;
                        end else begin
                            stored_d = TRUE;
                        end
                    end else if (if_out_mem_io) begin
                        state_d = MEM_IO_ADDR;
                    end
                end
                MEM_STORE: begin
                    if (bus_gnt) begin
                        mem_a    = addr_q + ADDR_WIDTH'(cnt_q);
                        mem_dout = 8'(data_q >> lane_shift);
                        if (!io_stall) begin
                            mem_wr = TRUE;
                            if (cnt_q == size_q - 6'd1) begin
                                state_d  = MEM_IDLE;
                                cnt_d    = '0;
                                stored_d = TRUE;
                            end else begin
                                cnt_d = cnt_q + 6'd1;
                            end
                        end
                    end
                end
                MEM_IO_ADDR: begin
                    if (bus_gnt) begin
                        mem_a   = ADDR_WIDTH'(IO_ADDR);
                        state_d = MEM_IO_DATA;
                    end
                end
                MEM_IO_DATA: begin
                    if (bus_gnt) begin
                        mem_a = ADDR_WIDTH'(IO_ADDR);
                    end
                    data_mem_d = DATA_WIDTH'(mem_din);
                    get_d      = TRUE;
                    state_d    = MEM_IDLE;
                end
                default: begin
                    state_d = MEM_IDLE;
                end
            endcase
        end

        if (!rdy) begin
            mem_a    = '0;
            mem_dout = '0;
            mem_wr   = FALSE;
        end
    end

    // State, byte counter and completion pulse registers; frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= '0;
            if_stored  <= FALSE;
            if_get_mem <= FALSE;
            data_mem   <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if_stored  <= stored_d;
            if_get_mem <= get_d;
            data_mem   <= data_mem_d;
        end
    end

    // Request latch: address, data and size captured when a store is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            size_q <= '0;
        end else if (rdy && latch_store) begin
            addr_q <= out_mem_addr;
            data_q <= out_mem_data;
            size_q <= out_mem_size;
        end
    end

endmodule

// File: tb/tb_rob_mem_responder.sv
// Directed self-checking bench for rob_mem_responder.
module tb_rob_mem_responder;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        if_out_mem;
    logic [5:0]  out_mem_size;
    logic [31:0] out_mem_addr;
    logic [31:0] out_mem_data;
    logic        if_stored;
    logic        if_out_mem_io;
    logic        if_get_mem;
    logic [31:0] data_mem;
    logic        bus_req;
    logic        bus_gnt;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int total = 0;
    int bad   = 0;

    rob_mem_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .IO_ADDR(32'h0003_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .clear(clear),
        .if_out_mem(if_out_mem),
        .out_mem_size(out_mem_size),
        .out_mem_addr(out_mem_addr),
        .out_mem_data(out_mem_data),
        .if_stored(if_stored),
        .if_out_mem_io(if_out_mem_io),
        .if_get_mem(if_get_mem),
        .data_mem(data_mem),
        .bus_req(bus_req),
        .bus_gnt(bus_gnt),
        .mem_din(mem_din),
        .mem_dout(mem_dout),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step to the start of the next cycle (just after the rising edge).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        total++;
        if ({if_stored, if_get_mem, bus_req, mem_wr, mem_dout, mem_a, data_mem} !== 75'd0)
            begin bad++; $display("FAIL reset_outputs got st=%b gm=%b req=%b wr=%b dout=%h a=%h dm=%h required all 0",
                if_stored, if_get_mem, bus_req, mem_wr, mem_dout, mem_a, data_mem); end
        cyc();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sw();
        logic [7:0] exp_b [4];
        logic [31:0] ea;
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        cyc();
        if_out_mem = 1'b1; out_mem_size = 6'd4; out_mem_addr = 32'h100;
        out_mem_data = 32'hDEADBEEF; bus_gnt = 1'b1;
        @(negedge clk);
        total++;
        if (bus_req !== 1'b0) begin bad++; $display("FAIL sw_req_T got=%b required=0", bus_req); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            if_out_mem = 1'b0;
            @(negedge clk);
            ea = 32'h100 + 32'(k);
            total++;
            if ({bus_req, mem_wr, mem_a, mem_dout, if_stored} !== {1'b1, 1'b1, ea, exp_b[k], 1'b0})
                begin bad++; $display("FAIL sw_byte%0d got req=%b wr=%b a=%h d=%h st=%b required 1 1 %h %h 0",
                    k, bus_req, mem_wr, mem_a, mem_dout, if_stored, ea, exp_b[k]); end
        end
        cyc();
        @(negedge clk);
        total++;
        if ({if_stored, bus_req, mem_wr} !== 3'b100)
            begin bad++; $display("FAIL sw_done got st=%b req=%b wr=%b required 1 0 0", if_stored, bus_req, mem_wr); end
        cyc();
        @(negedge clk);
        total++;
        if (if_stored !== 1'b0) begin bad++; $display("FAIL sw_pulse_once got=%b required=0", if_stored); end
    endtask

    task automatic test_sb_stall();
        logic exp_wr [6];
        logic exp_st [6];
        logic full_v [6];
        int   pulses;
        exp_wr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_st = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        full_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        pulses = 0;
        cyc();
        if_out_mem = 1'b1; out_mem_size = 6'd1; out_mem_addr = 32'h30000;
        out_mem_data = 32'h12345678; bus_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if_out_mem = 1'b0;
            io_buffer_full = full_v[k];
            @(negedge clk);
            if (if_stored === 1'b1) pulses++;
            total++;
            if ({mem_wr, if_stored} !== {exp_wr[k], exp_st[k]})
                begin bad++; $display("FAIL sb_cycle%0d got wr=%b st=%b required %b %b",
                    k + 1, mem_wr, if_stored, exp_wr[k], exp_st[k]); end
            if (exp_wr[k]) begin
                total++;
                if ({mem_a, mem_dout} !== {32'h30000, 8'h78})
                    begin bad++; $display("FAIL sb_write got a=%h d=%h required 00030000 78", mem_a, mem_dout); end
            end
        end
        io_buffer_full = 1'b0;
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL sb_pulse_count got=%0d required=1", pulses); end
    endtask

    task automatic test_io_read();
        cyc();
        if_out_mem_io = 1'b1; bus_gnt = 1'b1;
        cyc();
        if_out_mem_io = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_req, mem_wr, mem_a} !== {1'b1, 1'b0, 32'h30000})
            begin bad++; $display("FAIL io_addr got req=%b wr=%b a=%h required 1 0 00030000", bus_req, mem_wr, mem_a); end
        cyc();
        mem_din = 8'h41;
        @(negedge clk);
        total++;
        if ({if_get_mem, mem_a} !== {1'b0, 32'h30000})
            begin bad++; $display("FAIL io_capture got gm=%b a=%h required 0 00030000", if_get_mem, mem_a); end
        cyc();
        mem_din = 8'h00;
        @(negedge clk);
        total++;
        if ({if_get_mem, data_mem, bus_req} !== {1'b1, 32'h41, 1'b0})
            begin bad++; $display("FAIL io_done got gm=%b dm=%h req=%b required 1 00000041 0", if_get_mem, data_mem, bus_req); end
        cyc();
        @(negedge clk);
        total++;
        if (if_get_mem !== 1'b0) begin bad++; $display("FAIL io_pulse_once got=%b required=0", if_get_mem); end
    endtask

    task automatic test_sh_gnt();
        logic        gnt_v [5];
        logic [41:0] exp_v [5];
        logic        exp_req [5];
        gnt_v   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_v   = '{{1'b1, 32'h200, 8'hFE, 1'b0}, 42'd0, 42'd0,
                    {1'b1, 32'h201, 8'hCA, 1'b0}, {1'b0, 32'h0, 8'h0, 1'b1}};
        exp_req = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        cyc();
        if_out_mem = 1'b1; out_mem_size = 6'd2; out_mem_addr = 32'h200;
        out_mem_data = 32'h0000CAFE; bus_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if_out_mem = 1'b0;
            bus_gnt = gnt_v[k];
            @(negedge clk);
            total++;
            if ({mem_wr, mem_a, mem_dout, if_stored} !== exp_v[k] || bus_req !== exp_req[k])
                begin bad++; $display("FAIL sh_cycle%0d got wr=%b a=%h d=%h st=%b req=%b required %h req=%b",
                    k + 1, mem_wr, mem_a, mem_dout, if_stored, bus_req, exp_v[k], exp_req[k]); end
        end
        bus_gnt = 1'b1;
    endtask

    task automatic test_clear();
        cyc();
        if_out_mem = 1'b1; out_mem_size = 6'd4; out_mem_addr = 32'h300;
        out_mem_data = 32'h44332211; bus_gnt = 1'b1;
        cyc();
        if_out_mem = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h300, 8'h11})
            begin bad++; $display("FAIL clr_byte0 got wr=%b a=%h d=%h required 1 00000300 11", mem_wr, mem_a, mem_dout); end
        cyc();
        clear = 1'b1;
        @(negedge clk);
        total++;
        if (mem_wr !== 1'b0) begin bad++; $display("FAIL clr_no_write got=%b required=0", mem_wr); end
        cyc();
        clear = 1'b0;
        if_out_mem = 1'b1; out_mem_size = 6'd1; out_mem_addr = 32'h400; out_mem_data = 32'h99;
        @(negedge clk);
        total++;
        if ({bus_req, mem_wr, if_stored} !== 3'b000)
            begin bad++; $display("FAIL clr_idle got req=%b wr=%b st=%b required 0 0 0", bus_req, mem_wr, if_stored); end
        cyc();
        if_out_mem = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_wr, mem_a, mem_dout, if_stored} !== {1'b1, 32'h400, 8'h99, 1'b0})
            begin bad++; $display("FAIL clr_new_req got wr=%b a=%h d=%h st=%b required 1 00000400 99 0",
                mem_wr, mem_a, mem_dout, if_stored); end
        cyc();
        @(negedge clk);
        total++;
        if (if_stored !== 1'b1) begin bad++; $display("FAIL clr_new_done got=%b required=1", if_stored); end
        cyc();
        @(negedge clk);
        total++;
        if ({if_stored, bus_req} !== 2'b00)
            begin bad++; $display("FAIL clr_quiet got st=%b req=%b required 0 0", if_stored, bus_req); end
    endtask

    task automatic test_rdy_rst();
        logic [7:0]  exp_b [3];
        logic [31:0] ea;
        exp_b = '{8'h0B, 8'h0C, 8'h0D};
        cyc();
        if_out_mem = 1'b1; out_mem_size = 6'd4; out_mem_addr = 32'h500;
        out_mem_data = 32'h0D0C0B0A; bus_gnt = 1'b1;
        cyc();
        if_out_mem = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h500, 8'h0A})
            begin bad++; $display("FAIL rdy_byte0 got wr=%b a=%h d=%h required 1 00000500 0a", mem_wr, mem_a, mem_dout); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            rdy = 1'b0;
            @(negedge clk);
            total++;
            if ({mem_wr, bus_req, if_stored} !== 3'b010)
                begin bad++; $display("FAIL rdy_hold%0d got wr=%b req=%b st=%b required 0 1 0", k, mem_wr, bus_req, if_stored); end
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            rdy = 1'b1;
            @(negedge clk);
            ea = 32'h501 + 32'(k);
            total++;
            if ({mem_wr, mem_a, mem_dout} !== {1'b1, ea, exp_b[k]})
                begin bad++; $display("FAIL rdy_resume%0d got wr=%b a=%h d=%h required 1 %h %h",
                    k, mem_wr, mem_a, mem_dout, ea, exp_b[k]); end
        end
        cyc();
        @(negedge clk);
        total++;
        if (if_stored !== 1'b1) begin bad++; $display("FAIL rdy_done got=%b required=1", if_stored); end
        // reset in the middle of an IO read
        cyc();
        if_out_mem_io = 1'b1;
        cyc();
        if_out_mem_io = 1'b0;
        @(negedge clk);
        total++;
        if (mem_a !== 32'h30000) begin bad++; $display("FAIL rst_io_addr got=%h required=00030000", mem_a); end
        cyc();
        rst = 1'b1; mem_din = 8'h55;
        for (int k = 0; k < 2; k++) begin
            cyc();
            rst = 1'b0; mem_din = 8'h00;
            @(negedge clk);
            total++;
            if ({if_stored, if_get_mem, bus_req, mem_wr, mem_dout, mem_a, data_mem} !== 75'd0)
                begin bad++; $display("FAIL rst_mid_io%0d got gm=%b req=%b wr=%b a=%h dm=%h required all 0",
                    k, if_get_mem, bus_req, mem_wr, mem_a, data_mem); end
        end
    endtask

    task automatic test_invalid_size();
        cyc();
        if_out_mem = 1'b1; out_mem_size = 6'd3; out_mem_addr = 32'h600; out_mem_data = 32'hFFFF_FFFF;
        cyc();
        if_out_mem = 1'b0;
        @(negedge clk);
        total++;
        if ({if_stored, bus_req, mem_wr} !== 3'b100)
            begin bad++; $display("FAIL bad_size got st=%b req=%b wr=%b required 1 0 0", if_stored, bus_req, mem_wr); end
        cyc();
        @(negedge clk);
        total++;
        if ({if_stored, bus_req} !== 2'b00)
            begin bad++; $display("FAIL bad_size_after got st=%b req=%b required 0 0", if_stored, bus_req); end
    endtask

    task automatic test_both_pulses();
        cyc();
        if_out_mem = 1'b1; if_out_mem_io = 1'b1; out_mem_size = 6'd1;
        out_mem_addr = 32'h700; out_mem_data = 32'hAB; bus_gnt = 1'b1;
        cyc();
        if_out_mem = 1'b0; if_out_mem_io = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h700, 8'hAB})
            begin bad++; $display("FAIL both_store_wins got wr=%b a=%h d=%h required 1 00000700 ab", mem_wr, mem_a, mem_dout); end
        cyc();
        @(negedge clk);
        total++;
        if ({if_stored, if_get_mem} !== 2'b10)
            begin bad++; $display("FAIL both_done got st=%b gm=%b required 1 0", if_stored, if_get_mem); end
        cyc();
        @(negedge clk);
        total++;
        if ({bus_req, if_get_mem} !== 2'b00)
            begin bad++; $display("FAIL both_io_dropped got req=%b gm=%b required 0 0", bus_req, if_get_mem); end
    endtask

    task automatic test_back_to_back();
        cyc();
        if_out_mem = 1'b1; out_mem_size = 6'd1; out_mem_addr = 32'h800;
        out_mem_data = 32'h5A; bus_gnt = 1'b1;
        cyc();
        if_out_mem = 1'b0;
        cyc();
        if_out_mem_io = 1'b1;
        @(negedge clk);
        total++;
        if (if_stored !== 1'b1) begin bad++; $display("FAIL b2b_stored got=%b required=1", if_stored); end
        cyc();
        if_out_mem_io = 1'b0;
        @(negedge clk);
        total++;
        if ({bus_req, mem_a} !== {1'b1, 32'h30000})
            begin bad++; $display("FAIL b2b_io_accepted got req=%b a=%h required 1 00030000", bus_req, mem_a); end
        cyc();
        mem_din = 8'h33;
        cyc();
        mem_din = 8'h00;
        @(negedge clk);
        total++;
        if ({if_get_mem, data_mem} !== {1'b1, 32'h33})
            begin bad++; $display("FAIL b2b_io_done got gm=%b dm=%h required 1 00000033", if_get_mem, data_mem); end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        if_out_mem = 1'b0; out_mem_size = '0; out_mem_addr = '0; out_mem_data = '0;
        if_out_mem_io = 1'b0; bus_gnt = 1'b0; mem_din = '0; io_buffer_full = 1'b0;
        test_reset();
        test_sw();
        test_sb_stall();
        test_io_read();
        test_sh_gnt();
        test_clear();
        test_rdy_rst();
        test_invalid_size();
        test_both_pulses();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
